// File: rtl/register_file.sv
// register_file: two-read/one-write register file with per-register pending scoreboard
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_enable,
   input  logic [ADDR_W-1:0] w_address,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] r_address1,
   input  logic [ADDR_W-1:0] r_address2,
   output logic [DATA_W-1:0] r_out1,
   output logic [DATA_W-1:0] r_out2,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_address,
   output logic              r_pending1,
   output logic              r_pending2,
   output logic              any_pending
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending, pend_nxt;
   logic              wr;
   logic [DATA_W-1:0] rd1, rd2;
   assign wr = w_enable && !(ZERO_REG && w_address == '0);
   assign rd1 = (ZERO_REG && r_address1 == '0) ? '0 :
                (BYPASS && wr && w_address == r_address1) ? w_data : regs[r_address1];
   assign rd2 = (ZERO_REG && r_address2 == '0) ? '0 :
                (BYPASS && wr && w_address == r_address2) ? w_data : regs[r_address2];
   assign any_pending = |pending;
   // scoreboard update: clear on write, then set on issue so a same-edge set wins
   always_comb begin
      pend_nxt = pending;
      if (w_enable) pend_nxt[w_address] = 1'b0;
      if (issue_valid) pend_nxt[issue_address] = 1'b1;
      if (ZERO_REG) pend_nxt[0] = 1'b0;
   end
   // register storage and pending bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pending <= '0;
      end else begin
         if (wr) regs[w_address] <= w_data;
         pending <= pend_nxt;
      end
   end
   // registered read ports; pending reflects the post-update scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out1     <= '0;
         r_out2     <= '0;
         r_pending1 <= 1'b0;
         r_pending2 <= 1'b0;
      end else begin
         r_out1     <= rd1;
         r_out2     <= rd2;
         r_pending1 <= pend_nxt[r_address1];
         r_pending2 <= pend_nxt[r_address2];
      end
   end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, SHALL make register 0 hardwired to zero when 1, or an ordinary register when 0.
REQ-004 Parameter BYPASS, default 1, SHALL make same-cycle reads return the write data when 1, or the stored data when 0.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 w_enable  input  1  SHALL qualify a write this cycle.
REQ-008 w_address  input  ADDR_W  SHALL be the write register index.
REQ-009 w_data  input  DATA_W  SHALL be the write data.
REQ-010 r_address1, r_address2  input  ADDR_W each  SHALL be the read indices for ports 1 and 2.
REQ-011 r_out1, r_out2  output  DATA_W each  SHALL be the registered read data for ports 1 and 2.
REQ-012 issue_valid  input  1  SHALL qualify marking issue_address pending.
REQ-013 issue_address  input  ADDR_W  SHALL be the destination index of a newly issued instruction.
REQ-014 r_pending1, r_pending2  output  1 each  SHALL be the registered pending flag of the register read on ports 1 and 2.
REQ-015 any_pending  output  1  SHALL be high while any pending bit is set.

Function
REQ-016 Storage: 2**ADDR_W registers of DATA_W bits plus one pending bit per register.
REQ-017 Write: on rising edge with w_enable=1, register[w_address] SHALL take w_data, visible to reads from the next edge.
REQ-018 Read latency: exactly 1 cycle; r_outN and r_pendingN sampled from r_addressN at the edge, held until the next edge.
REQ-019 Both read ports independent; equal addresses on both ports SHALL return identical data.
REQ-020 Read/write collision, BYPASS=1: r_outN SHALL equal w_data at the edge where w_enable=1 and r_addressN=w_address.
REQ-021 Read/write collision, BYPASS=0: r_outN SHALL equal the pre-write content.
REQ-022 ZERO_REG=1: writes to address 0 ignored; reads of address 0 SHALL return 0 regardless of BYPASS; pending bit 0 never set.
REQ-023 Scoreboard set: issue_valid=1 SHALL set pending[issue_address] at the edge.
REQ-024 Scoreboard clear: w_enable=1 SHALL clear pending[w_address] at the edge.
REQ-025 Simultaneous set and clear of the same address: set wins (pending stays 1).
REQ-026 Pending bypass: r_pendingN at a collision edge SHALL reflect the post-update pending value, independent of BYPASS.
REQ-027 Set of an already-pending register: no error, bit stays 1; clear of a non-pending register: no effect beyond the data write.
REQ-028 any_pending SHALL be combinational OR of the pending bits (current state, no extra latency).
REQ-029 Address ranges: all ADDR_W-bit values are valid; no wrap or out-of-range handling required.

Reset
REQ-030 rst_n low SHALL immediately clear all registers, all pending bits, r_out1, r_out2, r_pending1, r_pending2 to 0, independent of clk.
REQ-031 While rst_n low, writes and issues SHALL be ignored; any_pending SHALL read 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight writes/issues; first edge after deassertion operates normally.

Verification
REQ-033 Write 0xDEADBEEF to r5, read r5 on both ports next cycle -> r_out1=r_out2=0xDEADBEEF one cycle after address applied.
REQ-034 Write 0x12345678 to r7 while reading r7, BYPASS=1 -> r_out1=0x12345678; BYPASS=0 -> previous value (0 after reset).
REQ-035 ZERO_REG=1, write 0xFFFFFFFF to r0, read r0 -> r_out1=0, r_pending1=0; ZERO_REG=0 same stimulus -> 0xFFFFFFFF.
REQ-036 Issue r3, read r3 -> r_pending1=1, any_pending=1; write r3 -> r_pending1=0, any_pending=0; issue and write r3 same edge -> r_pending1=1.
REQ-037 Fill all 32 registers with index*0x01010101, assert rst_n low between clocks -> all outputs 0 immediately; every subsequent read returns 0.
REQ-038 DATA_W=8, ADDR_W=3 build: write 0xA5 to r7, read r7 -> 0xA5; writes to r0..r7 do not alias.
